// File: rtl/mips150_mem_arbiter_pkg.sv
// Shared definitions for the MIPS150 fetch/data memory arbiter:
// FSM state encoding, access-size codes and the read byte-enable pattern.
package mips150_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_I  = 3'd1,
        ST_REQ_D  = 3'd2,
        ST_WAIT_I = 3'd3,
        ST_WAIT_D = 3'd4
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_READ = 4'b0000;

endpackage

// File: rtl/mips150_mem_arbiter_byte_lane.sv
// mips150_byte_lane: maps access size and low address bits to byte enables,
// lane-replicated store data and a misalignment flag. Size 11 behaves as word.
module mips150_byte_lane
    import mips150_mem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        misalign
);

    // Lane decode for each access size
    always_comb begin
        be         = 4'b1111;
        lane_wdata = wdata;
        misalign   = 1'b0;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << addr;
                lane_wdata = {4{wdata[7:0]}};
                misalign   = 1'b0;
            end
            SZ_HALF: begin
                be         = 4'b0011 << {addr[1], 1'b0};
                lane_wdata = {2{wdata[15:0]}};
                misalign   = addr[0];
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = wdata;
                misalign   = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mips150_mem_arbiter.sv
// mips150_mem_arbiter: shares one memory port between fetch and load/store with
// bounded fetch starvation. Define MIPS150_MEM_ARB_PERF_EN for stall counters.
module mips150_mem_arbiter
    import mips150_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_misalign,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic              m_ack,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata
`ifdef MIPS150_MEM_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [31:0]       perf_i_stall,
    output logic [31:0]       perf_d_stall
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t  state_r;
    logic [3:0]  starve_cnt_r;
    logic        fetch_win_s;
    logic        data_win_s;
    logic [3:0]  be_s;
    logic [31:0] lane_wdata_s;
    logic        misalign_s;

    mips150_byte_lane u_byte_lane (
        .size       (d_size),
        .addr       (d_addr[1:0]),
        .wdata      (d_wdata),
        .be         (be_s),
        .lane_wdata (lane_wdata_s),
        .misalign   (misalign_s)
    );

    // Grant decision, only ever made in IDLE and never while reset is held
    always_comb begin
        fetch_win_s = 1'b0;
        data_win_s  = 1'b0;
        if (rst_n && (state_r == ST_IDLE)) begin
            if (i_req && d_req) begin
                if (starve_cnt_r == STARVE_LIM) begin
                    fetch_win_s = 1'b1;
                end else begin
                    data_win_s = 1'b1;
                end
            end else begin
                fetch_win_s = i_req;
                data_win_s  = d_req;
            end
        end else begin
            fetch_win_s = 1'b0;
            data_win_s  = 1'b0;
        end
    end

    assign i_gnt = fetch_win_s;
    assign d_gnt = data_win_s;

    // Arbitration FSM: launches the memory request and returns read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= 4'd0;
            m_req        <= 1'b0;
            m_addr       <= {ADDR_W{1'b0}};
            m_be         <= BE_READ;
            m_wdata      <= 32'd0;
            i_rvalid     <= 1'b0;
            i_rdata      <= 32'd0;
            d_rvalid     <= 1'b0;
            d_rdata      <= 32'd0;
            d_misalign   <= 1'b0;
        end else begin
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            d_misalign <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fetch_win_s) begin
                        starve_cnt_r <= 4'd0;
                        m_req        <= 1'b1;
                        m_addr       <= {i_addr[ADDR_W-1:2], 2'b00};
                        m_be         <= BE_READ;
                        m_wdata      <= 32'd0;
                        state_r      <= ST_REQ_I;
                    end else if (data_win_s) begin
                        if (i_req && (starve_cnt_r != STARVE_LIM)) begin
                            starve_cnt_r <= starve_cnt_r + 4'd1;
                        end
                        // A misaligned access is granted but dropped without touching memory
                        if (misalign_s) begin
                            d_misalign <= 1'b1;
                        end else begin
                            m_req   <= 1'b1;
                            m_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                            m_be    <= d_we ? be_s : BE_READ;
                            m_wdata <= lane_wdata_s;
                            state_r <= ST_REQ_D;
                        end
                    end
                end
                ST_REQ_I, ST_REQ_D: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        if (m_be != BE_READ) begin
                            state_r <= ST_IDLE;
                        end else if (m_rvalid) begin
                            state_r <= ST_IDLE;
                            if (state_r == ST_REQ_I) begin
                                i_rdata  <= m_rdata;
                                i_rvalid <= 1'b1;
                            end else begin
                                d_rdata  <= m_rdata;
                                d_rvalid <= 1'b1;
                            end
                        end else if (state_r == ST_REQ_I) begin
                            state_r <= ST_WAIT_I;
                        end else begin
                            state_r <= ST_WAIT_D;
                        end
                    end
                end
                ST_WAIT_I: begin
                    if (m_rvalid) begin
                        i_rdata  <= m_rdata;
                        i_rvalid <= 1'b1;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_WAIT_D: begin
                    if (m_rvalid) begin
                        d_rdata  <= m_rdata;
                        d_rvalid <= 1'b1;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    m_req   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MIPS150_MEM_ARB_PERF_EN
    // Saturating stall-cycle counters; perf_clr takes priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_i_stall <= 32'd0;
            perf_d_stall <= 32'd0;
        end else if (perf_clr) begin
            perf_i_stall <= 32'd0;
            perf_d_stall <= 32'd0;
        end else begin
            if (i_req && !fetch_win_s && (perf_i_stall != 32'hFFFF_FFFF)) begin
                perf_i_stall <= perf_i_stall + 32'd1;
            end
            if (d_req && !data_win_s && (perf_d_stall != 32'hFFFF_FFFF)) begin
                perf_d_stall <= perf_d_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips150_mem_arbiter.sv
// Randomized self-checking bench for mips150_mem_arbiter against a transaction-level
// model with a byte-addressed memory. Honours MIPS150_MEM_ARB_PERF_EN when defined.
module tb_mips150_mem_arbiter;

    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, i_gnt, i_rvalid;
    logic [31:0] i_addr = 32'd0, i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid, d_misalign;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_addr = 32'd0, d_wdata = 32'd0, d_rdata;
    logic        m_req, m_ack = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_addr, m_wdata, m_rdata = 32'd0;
    logic [3:0]  m_be;
    logic        perf_clr = 1'b0;
`ifdef MIPS150_MEM_ARB_PERF_EN
    logic [31:0] perf_i_stall, perf_d_stall;
`endif

    mips150_mem_arbiter #(.STARVE_MAX(SMAX), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_misalign(d_misalign),
        .m_req(m_req), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
`ifdef MIPS150_MEM_ARB_PERF_EN
        , .perf_clr(perf_clr), .perf_i_stall(perf_i_stall), .perf_d_stall(perf_d_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte-addressed memory image (address bits [9:0] select a byte)
    logic [7:0] mem_b [0:1023];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int b;
        b = int'(a[9:2]) * 4;
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        else if (sz == 2'b01) return 2;
        else return 4;
    endfunction

    // Requester intent
    bit          i_pend = 1'b0, d_pend = 1'b0, d_w = 1'b0;
    logic [31:0] i_a = 32'd0, d_a = 32'd0, d_wd = 32'd0;
    logic [1:0]  d_sz = 2'b00;

    // Transaction-level model state
    bit          busy = 1'b0, acked = 1'b0, t_src_d = 1'b0, t_we = 1'b0;
    logic [31:0] t_addr = 32'd0, t_wdata = 32'd0;
    int          t_n = 4, ack_wait = 0, rv_wait = 0, dwins = 0;
    bit          exp_irv = 1'b0, exp_drv = 1'b0, exp_mis = 1'b0;
    logic [31:0] exp_idata = 32'd0, exp_ddata = 32'd0, exp_pi = 32'd0, exp_pd = 32'd0;

    // Stimulus knobs and observation counters
    int          ack_min = 0, ack_max = 0, rv_min = 0, rv_max = 0, req_pct = 0;
    bit          rv_block = 1'b0, force_rv = 1'b0, noise_on = 1'b0;
    int          irv_cnt = 0, drv_cnt = 0, mis_cnt = 0;
    logic [31:0] ack_addr = 32'd0, ack_wd = 32'd0;
    logic [3:0]  ack_be = 4'd0;
    bit          glog [$];

    task automatic new_fetch();
        i_pend = 1'b1;
        i_a    = $urandom();
    endtask

    task automatic new_data();
        d_pend = 1'b1;
        d_w    = 1'($urandom_range(0, 1));
        d_sz   = 2'($urandom_range(0, 3));
        d_a    = $urandom();
        d_wd   = $urandom();
    endtask

    // One clock cycle: check registered outputs, act as memory, drive requests, check grants
    task automatic step();
        bit          busy0, just_ack, ei, ed;
        logic [3:0]  xbe;
        logic [31:0] xwd, word;
        @(negedge clk);
        check_eq("m_req", m_req, busy && !acked);
        check_eq("i_rvalid", i_rvalid, exp_irv);
        if (exp_irv) check_eq("i_rdata", i_rdata, exp_idata);
        check_eq("d_rvalid", d_rvalid, exp_drv);
        if (exp_drv) check_eq("d_rdata", d_rdata, exp_ddata);
        check_eq("d_misalign", d_misalign, exp_mis);
`ifdef MIPS150_MEM_ARB_PERF_EN
        check_eq("perf_i_stall", perf_i_stall, exp_pi);
        check_eq("perf_d_stall", perf_d_stall, exp_pd);
`endif
        if (i_rvalid) irv_cnt++;
        if (d_rvalid) drv_cnt++;
        if (d_misalign) mis_cnt++;
        exp_irv = 1'b0; exp_drv = 1'b0; exp_mis = 1'b0;

        busy0    = busy;
        just_ack = 1'b0;
        m_ack    = 1'b0;
        m_rvalid = force_rv;
        m_rdata  = $urandom();
        if (!busy0 && noise_on && ($urandom_range(0, 9) == 0)) m_rvalid = 1'b1;
        if (busy0 && !acked) begin
            if (ack_wait == 0) begin
                m_ack = 1'b1; acked = 1'b1; just_ack = 1'b1;
                xbe = 4'b0000;
                xwd = 32'd0;
                for (int k = 0; k < t_n; k++) xbe[int'(t_addr[1:0]) + k] = t_we;
                for (int l = 0; l < 4; l++) xwd[8*l +: 8] = t_wdata[8*(l % t_n) +: 8];
                ack_addr = m_addr; ack_be = m_be; ack_wd = m_wdata;
                check_eq("m_addr", m_addr, {t_addr[31:2], 2'b00});
                check_eq("m_be", m_be, xbe);
                if (t_we) begin
                    check_eq("m_wdata", m_wdata, xwd);
                    for (int k = 0; k < t_n; k++) mem_b[int'(t_addr[9:0]) + k] = t_wdata[8*k +: 8];
                    busy = 1'b0; acked = 1'b0;
                end else begin
                    rv_wait = rv_block ? 1000000 : $urandom_range(rv_min, rv_max);
                end
            end else begin
                ack_wait--;
            end
        end
        if (busy && acked) begin
            if (!just_ack) rv_wait--;
            if (rv_wait == 0) begin
                word = mem_word(t_addr);
                m_rvalid = 1'b1;
                m_rdata  = word;
                if (t_src_d) begin exp_drv = 1'b1; exp_ddata = word; end
                else begin exp_irv = 1'b1; exp_idata = word; end
                busy = 1'b0; acked = 1'b0;
            end
        end

        i_req = i_pend; i_addr = i_a;
        d_req = d_pend; d_we = d_w; d_size = d_sz; d_addr = d_a; d_wdata = d_wd;
        #1;
        ei = 1'b0; ed = 1'b0;
        if (!busy0) begin
            if (i_pend && d_pend) begin
                if (dwins == SMAX) ei = 1'b1;
                else ed = 1'b1;
            end else begin
                ei = i_pend; ed = d_pend;
            end
        end
        check_eq("i_gnt", i_gnt, ei);
        check_eq("d_gnt", d_gnt, ed);
        exp_pi = perf_clr ? 32'd0 : exp_pi + ((i_pend && !ei) ? 32'd1 : 32'd0);
        exp_pd = perf_clr ? 32'd0 : exp_pd + ((d_pend && !ed) ? 32'd1 : 32'd0);
        if (ei) begin
            glog.push_back(1'b1);
            dwins = 0;
            busy = 1'b1; acked = 1'b0; t_src_d = 1'b0; t_we = 1'b0;
            t_addr = i_a; t_n = 4; ack_wait = $urandom_range(ack_min, ack_max);
            i_pend = 1'b0;
        end
        if (ed) begin
            glog.push_back(1'b0);
            if (i_pend && dwins < SMAX) dwins++;
            // Natural alignment: the address must be a multiple of the access size
            if ((int'(d_a[1:0]) % size_bytes(d_sz)) != 0) begin
                exp_mis = 1'b1;
            end else begin
                busy = 1'b1; acked = 1'b0; t_src_d = 1'b1; t_we = d_w;
                t_addr = d_a; t_wdata = d_wd; t_n = size_bytes(d_sz);
                ack_wait = $urandom_range(ack_min, ack_max);
            end
            d_pend = 1'b0;
        end
        if (!i_pend && ($urandom_range(0, 99) < req_pct)) new_fetch();
        if (!d_pend && ($urandom_range(0, 99) < req_pct)) new_data();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy || i_pend || d_pend || exp_irv || exp_drv || exp_mis) && (k < 200)) begin
            step();
            k++;
        end
        check_eq("drain_bound", (k < 200), 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        #1;
        check_eq("rst_i_gnt", i_gnt, 1'b0);
        check_eq("rst_d_gnt", d_gnt, 1'b0);
        check_eq("rst_m_req", m_req, 1'b0);
        check_eq("rst_m_be", m_be, 4'b0000);
        check_eq("rst_m_addr", m_addr, 32'd0);
        check_eq("rst_rvalid", {i_rvalid, d_rvalid, d_misalign}, 3'b000);
        check_eq("rst_rdata", i_rdata | d_rdata | m_wdata, 32'd0);
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i_pend = 1'b0; d_pend = 1'b0; busy = 1'b0; acked = 1'b0; dwins = 0;
        exp_irv = 1'b0; exp_drv = 1'b0; exp_mis = 1'b0; exp_pi = 32'd0; exp_pd = 32'd0;
    endtask

    initial begin
        logic [7:0] gv;
        for (int k = 0; k < 1024; k++) mem_b[k] = 8'($urandom());
        do_reset();

        // Fetch only: word 0x100 holds DEADBEEF, read data one cycle after ack
        {mem_b[259], mem_b[258], mem_b[257], mem_b[256]} = 32'hDEAD_BEEF;
        rv_min = 1; rv_max = 1;
        irv_cnt = 0; glog.delete();
        i_pend = 1'b1; i_a = 32'h0000_0100;
        repeat (8) step();
        check_eq("fetch_rvalid_once", irv_cnt, 1);
        check_eq("fetch_m_addr", ack_addr, 32'h0000_0100);
        check_eq("fetch_m_be", ack_be, 4'b0000);
        check_eq("fetch_rdata_model", exp_idata, 32'hDEAD_BEEF);

        // Store byte to 0x203
        drv_cnt = 0;
        d_pend = 1'b1; d_w = 1'b1; d_sz = 2'b00; d_a = 32'h0000_0203; d_wd = 32'h0000_00AB;
        repeat (6) step();
        check_eq("sb_m_addr", ack_addr, 32'h0000_0200);
        check_eq("sb_m_be", ack_be, 4'b1000);
        check_eq("sb_m_wdata", ack_wd, 32'hABAB_ABAB);
        check_eq("sb_no_rvalid", drv_cnt, 0);

        // Continuous contention: d,d,d,i repeating
        glog.delete();
        ack_min = 0; ack_max = 2; rv_min = 0; rv_max = 2; req_pct = 100;
        new_fetch(); new_data();
        for (int k = 0; k < 300 && glog.size() < 8; k++) step();
        check_eq("contend_bound", (glog.size() >= 8), 1'b1);
        gv = 8'd0;
        for (int k = 0; k < 8 && k < glog.size(); k++) gv[7-k] = glog[k];
        check_eq("grant_order", gv, 8'b0001_0001);
        req_pct = 0;
        drain();

        // Misaligned word load, then a normal fetch
        mis_cnt = 0; irv_cnt = 0;
        d_pend = 1'b1; d_w = 1'b0; d_sz = 2'b10; d_a = 32'h0000_0102; d_wd = 32'd0;
        repeat (3) step();
        i_pend = 1'b1; i_a = 32'h0000_0040;
        drain();
        check_eq("mis_pulse_once", mis_cnt, 1);
        check_eq("mis_then_fetch", irv_cnt, 1);

        // Reset while waiting for load data, then stray m_rvalid
        rv_block = 1'b1; ack_min = 0; ack_max = 0;
        d_pend = 1'b1; d_w = 1'b0; d_sz = 2'b10; d_a = 32'h0000_0080;
        repeat (3) step();
        do_reset();
        rv_block = 1'b0; drv_cnt = 0; irv_cnt = 0;
        force_rv = 1'b1;
        step();
        force_rv = 1'b0;
        repeat (2) step();
        check_eq("rst_no_d_rvalid", drv_cnt, 0);
        i_pend = 1'b1; i_a = 32'h0000_0044;
        drain();
        check_eq("rst_then_fetch", irv_cnt, 1);

        // Fetch stalled five cycles behind a slow store
        perf_clr = 1'b1; step(); perf_clr = 1'b0;
        ack_min = 3; ack_max = 3;
        d_pend = 1'b1; d_w = 1'b1; d_sz = 2'b10; d_a = 32'h0000_0300; d_wd = $urandom();
        i_pend = 1'b1; i_a = 32'h0000_0104;
        repeat (6) step();
`ifdef MIPS150_MEM_ARB_PERF_EN
        check_eq("perf_i_five", perf_i_stall, 32'd5);
        perf_clr = 1'b1; step(); perf_clr = 1'b0;
        step();
        check_eq("perf_i_clr", perf_i_stall, 32'd0);
`endif
        drain();

        // Random traffic with random latencies and stray m_rvalid in IDLE
        ack_min = 0; ack_max = 3; rv_min = 0; rv_max = 3; req_pct = 30; noise_on = 1'b1;
        repeat (3000) step();
        req_pct = 0; noise_on = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
